// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES inverse-round sequencing controller.
//   state_t           : controller FSM states
//   AES128_NR         : round count for AES-128
//   STAGES_PER_ROUND  : datapath stage states per full inverse round
//   KIDX_W_DEF        : default width of the round-key index
//   is_stage()        : 1 for states that dwell on the stage timer
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT_ARK,
    SHIFT,
    SUB,
    ARK,
    MIX,
    DONE
  } state_t;

  localparam int AES128_NR        = 10;
  localparam int STAGES_PER_ROUND = 4;
  localparam int KIDX_W_DEF       = 4;

  function automatic logic is_stage(input state_t s);
    return (s == INIT_ARK) || (s == SHIFT) || (s == SUB) ||
           (s == ARK) || (s == MIX);
  endfunction

endpackage

// File: rtl/aes_stage_timer.sv
// Dwell timer for one datapath stage.
//   clk, rst     : clock, synchronous active-high reset
//   load         : the FSM enters a stage state on the next edge
//   first_cycle  : current cycle is the first of the dwell (strobe cycle)
//   last_cycle   : current cycle is the last of the dwell (exit cycle)
module aes_stage_timer #(
  parameter int STAGE_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic first_cycle,
  output logic last_cycle
);

  localparam int CW = 3;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      first_cycle <= 1'b0;
    end else if (load) begin
      cnt         <= CW'(STAGE_LAT - 1);
      first_cycle <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      first_cycle <= 1'b0;
    end
  end

  assign last_cycle = (cnt == '0);

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Sequencing controller for the iterative AES decryption datapath.
// Walks one block through: initial AddRoundKey, NR-1 full inverse rounds
// (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), and a final
// round without InvMixColumns. Each stage dwells STAGE_LAT cycles and its
// enable strobe fires in the first cycle of the dwell.
//   clk, rst                  : clock, synchronous active-high reset
//   start_valid / start_ready : block input handshake (ready only in IDLE)
//   abort                     : cancel the block in flight
//   done_valid / done_ready   : plaintext output handshake
//   busy                      : any state other than IDLE
//   en_add_key, en_inv_shift,
//   en_inv_sub, en_inv_mix    : one-cycle datapath register enables
//   sel_input                 : AddRoundKey operand, 1 = ciphertext input
//   key_idx                   : round-key index for the key store
//   round                     : current round counter
module aes_inv_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int STAGE_LAT = 1,
  parameter int KIDX_W    = KIDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic              abort,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              busy,
  output logic              en_add_key,
  output logic              en_inv_shift,
  output logic              en_inv_sub,
  output logic              en_inv_mix,
  output logic              sel_input,
  output logic [KIDX_W-1:0] key_idx,
  output logic [KIDX_W-1:0] round
);

  state_t state, state_n;
  logic   load, first_cycle, last_cycle;

  aes_stage_timer #(.STAGE_LAT(STAGE_LAT)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .first_cycle (first_cycle),
    .last_cycle  (last_cycle)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state != IDLE && abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:     if (start_valid) state_n = INIT_ARK;
        INIT_ARK: if (last_cycle)  state_n = SHIFT;
        SHIFT:    if (last_cycle)  state_n = SUB;
        SUB:      if (last_cycle)  state_n = ARK;
        // round 0 is the final round: skip InvMixColumns
        ARK:      if (last_cycle)  state_n = (round == '0) ? DONE : MIX;
        MIX:      if (last_cycle)  state_n = SHIFT;
        DONE:     if (done_ready)  state_n = IDLE;
        default:                   state_n = IDLE;
      endcase
    end
  end

  // every stage exit goes to a different state, so a state change into a
  // stage state is exactly when the dwell must restart
  assign load = is_stage(state_n) && (state_n != state);

  // round/key_idx: INIT_ARK uses key NR, then key_idx tracks round and both
  // step down together on each MIX exit
  always_ff @(posedge clk) begin
    if (rst) begin
      round   <= '0;
      key_idx <= '0;
    end else if (state == IDLE && state_n == INIT_ARK) begin
      round   <= KIDX_W'(NR - 1);
      key_idx <= KIDX_W'(NR);
    end else if (state_n == IDLE) begin
      round   <= '0;
      key_idx <= '0;
    end else if (state == INIT_ARK && state_n != state) begin
      key_idx <= round;
    end else if (state == MIX && state_n != state) begin
      round   <= round - 1'b1;
      key_idx <= key_idx - 1'b1;
    end
  end

  // registered so it stays low through the reset cycle
  always_ff @(posedge clk) begin
    if (rst) start_ready <= 1'b0;
    else     start_ready <= (state_n == IDLE);
  end

  assign busy         = (state != IDLE);
  assign done_valid   = (state == DONE);
  assign sel_input    = (state == INIT_ARK);
  assign en_add_key   = first_cycle && (state == INIT_ARK || state == ARK);
  assign en_inv_shift = first_cycle && (state == SHIFT);
  assign en_inv_sub   = first_cycle && (state == SUB);
  assign en_inv_mix   = first_cycle && (state == MIX);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: two instances (STAGE_LAT 1 and 3) share
// stimulus; a schedule model derives expected outputs from the elapsed
// cycle count of the block in flight.
module tb_aes_inv_round_ctrl;
  import aes_ctrl_pkg::*;

  localparam int NR = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic start_valid = 1'b0, abort = 1'b0, done_ready = 1'b0;

  typedef struct packed {
    logic sr, bz, dv, add, shf, sub, mix, sel;
    logic [3:0] key, rnd;
  } obs_t;

  obs_t o [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic sr, bz, dv, add, shf, sub, mix, sel;
    logic [3:0] key, rnd;
    aes_inv_round_ctrl #(.NR(NR), .STAGE_LAT(g == 0 ? 1 : 3), .KIDX_W(4)) u_dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr),
      .abort(abort), .done_valid(dv), .done_ready(done_ready), .busy(bz),
      .en_add_key(add), .en_inv_shift(shf), .en_inv_sub(sub), .en_inv_mix(mix),
      .sel_input(sel), .key_idx(key), .round(rnd)
    );
    assign o[g] = {sr, bz, dv, add, shf, sub, mix, sel, key, rnd};
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // phase 0 idle, 1 running (t = cycles since accept), 2 done
  typedef struct {
    int phase;
    int t;
    bit in_rst;
  } mdl_t;

  mdl_t m [2];
  int   sl [2] = '{1, 3};

  task automatic check_dut(input int i);
    obs_t e;
    bit   ck_key, ck_rnd;
    int   s, w, r, k;
    e = '0; ck_key = 0; ck_rnd = 0;
    case (m[i].phase)
      0: begin
        e.sr = !m[i].in_rst;
        ck_key = m[i].in_rst; ck_rnd = m[i].in_rst;
      end
      1: begin
        e.bz = 1'b1;
        s = (m[i].t - 1) / sl[i];
        w = (m[i].t - 1) % sl[i];
        ck_rnd = 1;
        if (s == 0) begin
          e.rnd = 4'(NR - 1);
          if (w == 0) begin e.add = 1; e.sel = 1; e.key = 4'(NR); ck_key = 1; end
        end else begin
          r = (s - 1) / STAGES_PER_ROUND;
          k = (s - 1) % STAGES_PER_ROUND;
          e.rnd = 4'(NR - 1 - r);
          if (w == 0) begin
            case (k)
              0: e.shf = 1;
              1: e.sub = 1;
              2: begin e.add = 1; e.key = e.rnd; ck_key = 1; end
              default: e.mix = 1;
            endcase
          end
        end
      end
      default: begin
        e.bz = 1; e.dv = 1; ck_rnd = 1;
      end
    endcase
    chk($sformatf("d%0d.start_ready", i), 32'(o[i].sr), 32'(e.sr));
    chk($sformatf("d%0d.busy", i), 32'(o[i].bz), 32'(e.bz));
    chk($sformatf("d%0d.done_valid", i), 32'(o[i].dv), 32'(e.dv));
    chk($sformatf("d%0d.strobes", i), 32'({o[i].add, o[i].shf, o[i].sub, o[i].mix}),
        32'({e.add, e.shf, e.sub, e.mix}));
    chk($sformatf("d%0d.onehot0", i),
        32'($countones({o[i].add, o[i].shf, o[i].sub, o[i].mix}) <= 1), 32'd1);
    if (e.add) chk($sformatf("d%0d.sel_input", i), 32'(o[i].sel), 32'(e.sel));
    if (ck_key) chk($sformatf("d%0d.key_idx", i), 32'(o[i].key), 32'(e.key));
    if (ck_rnd) chk($sformatf("d%0d.round", i), 32'(o[i].rnd), 32'(e.rnd));
  endtask

  // predict state after the next rising edge from the inputs now present
  task automatic step(input int i);
    if (rst) begin
      m[i].phase = 0; m[i].in_rst = 1;
    end else begin
      m[i].in_rst = 0;
      case (m[i].phase)
        0: if (start_valid) begin m[i].phase = 1; m[i].t = 1; end
        1: if (abort) m[i].phase = 0;
           else begin
             m[i].t++;
             if (m[i].t > 4 * NR * sl[i]) m[i].phase = 2;
           end
        default: if (abort || done_ready) m[i].phase = 0;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin m[i].phase = 0; m[i].t = 0; m[i].in_rst = 1; end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin check_dut(i); step(i); end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start_valid = 1'b1;
    cyc(1);
    start_valid = 1'b0;
  endtask

  initial begin : stim
    int  c;
    bit  got0, got3, found;
    cyc(3);
    rst = 1'b0;
    cyc(3);

    // single block, latency on both instances
    done_ready = 1'b1;
    start_pulse();
    c = 0; got0 = 0; got3 = 0;
    while (c < 400 && !(got0 && got3)) begin
      @(negedge clk);
      c++;
      if (o[0].dv && !got0) begin got0 = 1; chk("latency_sl1", 32'(c), 32'(4*NR*1+1)); end
      if (o[1].dv && !got3) begin got3 = 1; chk("latency_sl3", 32'(c), 32'(4*NR*3+1)); end
    end
    chk("latency_sl1_seen", 32'(got0), 32'd1);
    chk("latency_sl3_seen", 32'(got3), 32'd1);
    cyc(4);

    // backpressure in DONE
    done_ready = 1'b0;
    start_pulse();
    cyc(130);
    done_ready = 1'b1;
    cyc(4);

    // abort in SUB of round 5, restart two cycles later
    start_pulse();
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (o[0].shf && o[0].rnd == 4'd5) found = 1;
    end
    chk("abort_point_seen", 32'(found), 32'd1);
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    cyc(2);
    start_pulse();
    cyc(130);

    // reset during MIX
    start_pulse();
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (o[0].add && !o[0].sel && o[0].rnd == 4'd3) found = 1;
    end
    chk("mix_point_seen", 32'(found), 32'd1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);

    // start held high through runs
    start_valid = 1'b1;
    cyc(300);
    start_valid = 1'b0;
    cyc(130);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      start_valid = ($urandom_range(0, 1) == 0);
      done_ready  = ($urandom_range(0, 2) != 0);
      abort       = ($urandom_range(0, 149) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    start_valid = 1'b0; abort = 1'b0; rst = 1'b0; done_ready = 1'b1;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
- Sequencing controller for the iterative AES-128 decryption datapath.
- Steps one block through the inverse round stages in standard order:
  - initial AddRoundKey;
  - NR-1 full inverse rounds;
  - a final round with no InvMixColumns.
- Drives one-cycle enable strobes to the InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns registers, plus the round-key index for the key store.
- Sits between the block input handshake and the decrypt datapath.

Parameters:
- NR, 10, number of rounds (10 for AES-128); legal range 2..14.
- STAGE_LAT, 1, cycles each datapath stage needs from enable to registered result; legal range 1..4.
- KIDX_W, 4, width of key_idx.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  new ciphertext block present at datapath input.
- start_ready  out  1  controller idle and accepting a block.
- abort  in  1  synchronous cancel of the block in flight.
- done_valid  out  1  plaintext valid at datapath output.
- done_ready  in  1  consumer takes the plaintext.
- busy  out  1  block in flight (any state except IDLE).
- en_add_key  out  1  AddRoundKey register enable strobe.
- en_inv_shift  out  1  Inv_Shift_Rows en strobe.
- en_inv_sub  out  1  InvSubBytes enable strobe.
- en_inv_mix  out  1  InvMixColumns enable strobe.
- sel_input  out  1  AddRoundKey operand select: 1 = ciphertext input, 0 = InvSubBytes output.
- key_idx  out  KIDX_W  round-key index for the key store.
- round  out  KIDX_W  current round counter, for debug and status.

Behaviour:
- Reset: rst is synchronous, active-high, clock clk. While rst is high:
  - state = IDLE;
  - all strobes 0; done_valid = 0; busy = 0;
  - key_idx = 0; round = 0; sel_input = 0;
  - start_ready = 0 during the reset cycle, and 1 from the first cycle after rst deasserts.
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- States: IDLE, INIT_ARK, SHIFT, SUB, ARK, MIX, DONE.
- IDLE:
  - start_ready = 1.
  - start_valid high -> INIT_ARK, with round = NR-1 and key_idx = NR.
- Stage dwell and strobes:
  - Each stage state (INIT_ARK, SHIFT, SUB, ARK, MIX) dwells exactly STAGE_LAT cycles.
  - Its strobe is high only in the first cycle of the dwell.
  - INIT_ARK asserts en_add_key with sel_input = 1 and key_idx = NR.
- Transitions:
  - INIT_ARK -> SHIFT -> SUB -> ARK.
  - In ARK: en_add_key is high, sel_input = 0, key_idx = round.
  - ARK with round != 0 -> MIX.
  - ARK with round == 0 -> DONE (final round, no MIX).
  - MIX -> SHIFT, with round and key_idx decremented by 1 on the exit cycle.
- Totals:
  - 4*NR stage states in all.
  - done_valid first rises 4*NR*STAGE_LAT+1 cycles after the accepting edge (41 for the defaults).
- DONE:
  - done_valid held at 1 until done_ready is high, then -> IDLE.
  - start_ready stays 0 in DONE, so a new start is accepted no earlier than the cycle after the done handshake.
- abort:
  - Any non-IDLE state -> IDLE on the next edge.
  - Strobes and done_valid are 0 from that edge; no done is produced for the aborted block.
  - abort in IDLE is ignored.
  - abort and done_ready together in DONE -> IDLE; the handshake counts as completed.
- rst overrides abort and all handshakes.
- Exactly one strobe is high in any cycle, or none.
- key_idx never underflows: round 0 is always followed by DONE.
- start_valid while not IDLE is ignored; it is not queued.

Decomposition:
- Package aes_ctrl_pkg holds:
  - the state enumeration;
  - AES128_NR = 10;
  - a STAGES_PER_ROUND = 4 constant;
  - the KIDX_W default.
- One sub-module, aes_stage_timer:
  - load/count-down of STAGE_LAT;
  - produces first_cycle and last_cycle flags for the FSM.
- The FSM and counters live in aes_inv_round_ctrl.

Test Plan:
- Reset then idle (defaults): hold rst 3 cycles, release -> start_ready = 1, busy = 0, all strobes 0, key_idx = 0.
- Single block (NR=10, STAGE_LAT=1): start_valid pulse, done_ready = 1 ->
  - strobe sequence ADD(k10), then {SHIFT, SUB, ADD(k9..k1), MIX} x9, then SHIFT, SUB, ADD(k0);
  - done_valid rises on cycle 41 after the accept edge; start_ready returns on cycle 42.
- Backpressure: done_ready held 0 for 5 cycles in DONE -> done_valid stays 1 and no strobes fire; done_ready = 1 -> IDLE next cycle.
- STAGE_LAT=3: single block ->
  - each strobe is followed by 2 idle cycles;
  - done_valid rises 121 cycles after accept;
  - no two strobes within 3 cycles of each other.
- Abort mid-run: abort asserted in the SUB state of round 5 -> IDLE next cycle, no done_valid; a new start 2 cycles later completes normally, starting from key_idx = 10.
- Reset mid-operation and illegal starts:
  - rst in MIX -> all outputs return to reset values in the following cycle;
  - start_valid held high through a run -> exactly one block processed before DONE.
